// File: rtl/mux_8to1_rr_serializer.sv
// mux_8to1_rr_serializer
// Collects 1-bit items from 8 source lanes through per-lane req/ack capture
// registers and serialises them round-robin onto a (d, sel, enable) triple
// that feeds a 1-to-8 demultiplexer. Each item is presented for HOLD_CYCLES.
module mux_8to1_rr_serializer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x,
    input  logic [7:0] req,
    output logic [7:0] ack,
    output logic       d,
    output logic [2:0] sel,
    output logic       enable,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nx;

    logic [7:0] pending;
    logic [7:0] data_q;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [2:0] start;
    logic [2:0] gnt;
    logic       found;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       d_nx;
    logic       en_nx;
    logic [2:0] sel_nx;
    logic       last;

    // A lane captures whenever it requests and holds no item yet.
    assign cap  = req & ~pending;
    assign last = (state == SEND) && (cnt == '0);
    assign busy = (|pending) | enable;

    // Round-robin search. While sending, the search already looks ahead to the
    // grant that follows the current item: the lane being served is masked and
    // the order starts just after it, which is the pointer value it leaves behind.
    always_comb begin
        if (state == SEND) begin
            start = sel + 3'd1;
            cand  = pending & ~(8'b1 << sel);
        end else begin
            start = ptr;
            cand  = pending;
        end
        found = 1'b0;
        gnt   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!found && cand[start + 3'(k)]) begin
                found = 1'b1;
                gnt   = start + 3'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: leave IDLE on any grant, leave SEND only when the hold ends with nothing left.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = SEND;
            SEND:    if (last && !found) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath next values: load a grant, count down the hold, then retire or chain.
    always_comb begin
        d_nx   = d;
        sel_nx = sel;
        en_nx  = enable;
        cnt_nx = cnt;
        ptr_nx = ptr;
        clr    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    en_nx  = 1'b1;
                    sel_nx = gnt;
                    d_nx   = data_q[gnt];
                    cnt_nx = HOLD_RELOAD;
                end
            end
            SEND: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    clr    = 8'b1 << sel;
                    ptr_nx = sel + 3'd1;
                    if (found) begin
                        en_nx  = 1'b1;
                        sel_nx = gnt;
                        d_nx   = data_q[gnt];
                        cnt_nx = HOLD_RELOAD;
                    end else begin
                        en_nx  = 1'b0;
                        sel_nx = '0;
                        d_nx   = 1'b0;
                        cnt_nx = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Capture registers, ack pulses and registered output triple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            data_q  <= '0;
            ack     <= '0;
            d       <= 1'b0;
            sel     <= '0;
            enable  <= 1'b0;
            cnt     <= '0;
            ptr     <= '0;
        end else begin
            pending <= (pending & ~clr) | cap;
            data_q  <= (data_q & ~cap) | (x & cap);
            ack     <= cap;
            d       <= d_nx;
            sel     <= sel_nx;
            enable  <= en_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
        end
    end

endmodule

// File: tb/tb_mux_8to1_rr_serializer.sv
// Testbench for mux_8to1_rr_serializer: two instances (HOLD_CYCLES 1 and 3)
// checked every cycle against an array-based reference model, plus directed
// scenarios with hand-derived expected sequences.
module tb_mux_8to1_rr_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x_v    [2];
    logic [7:0] req_v  [2];
    logic [7:0] ack_v  [2];
    logic       d_v    [2];
    logic [2:0] sel_v  [2];
    logic       en_v   [2];
    logic       busy_v [2];

    int checks = 0;
    int errors = 0;

    // reference model state, one slot per instance
    int       m_hold [2] = '{1, 3};
    bit [7:0] m_pend [2];
    bit [7:0] m_val  [2];
    bit [7:0] m_ack  [2];
    int       m_ptr  [2];
    int       m_cur  [2];
    int       m_rem  [2];
    bit       m_act  [2];
    bit       m_d    [2];
    bit [7:0] rel    [2];

    // expected lane-2 timeline for the HOLD_CYCLES=3 scenario, cycles 2..10
    bit t4_en  [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};
    bit t4_d   [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    int t4_ack [9] = '{0, 0, 0, 0, 4, 0, 0, 0, 0};

    logic [7:0] pat;
    int         na;
    int         ne;

    always #5 clk = ~clk;

    mux_8to1_rr_serializer #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .x(x_v[0]), .req(req_v[0]), .ack(ack_v[0]),
        .d(d_v[0]), .sel(sel_v[0]), .enable(en_v[0]), .busy(busy_v[0])
    );

    mux_8to1_rr_serializer #(.HOLD_CYCLES(3)) dut_h3 (
        .clk(clk), .rst_n(rst_n), .x(x_v[1]), .req(req_v[1]), .ack(ack_v[1]),
        .d(d_v[1]), .sel(sel_v[1]), .enable(en_v[1]), .busy(busy_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_pend[u] = '0;
        m_val[u]  = '0;
        m_ack[u]  = '0;
        m_ptr[u]  = 0;
        m_cur[u]  = 0;
        m_rem[u]  = 0;
        m_act[u]  = 1'b0;
        m_d[u]    = 1'b0;
    endtask

    function automatic int find(input int u, input int from);
        for (int k = 0; k < 8; k++) begin
            if (m_pend[u][(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic begin_item(input int u, input int g);
        m_act[u] = 1'b1;
        m_cur[u] = g;
        m_d[u]   = m_val[u][g];
        m_rem[u] = m_hold[u] - 1;
    endtask

    // one clock edge of the model: grants look at items held before this edge
    task automatic model_step(input int u, input bit [7:0] r, input bit [7:0] xx);
        bit [7:0] cp;
        int       g;
        cp = r & ~m_pend[u];
        if (!m_act[u]) begin
            g = find(u, m_ptr[u]);
            if (g >= 0) begin_item(u, g);
        end else if (m_rem[u] > 0) begin
            m_rem[u] = m_rem[u] - 1;
        end else begin
            m_pend[u][m_cur[u]] = 1'b0;
            m_ptr[u] = (m_cur[u] + 1) % 8;
            g = find(u, m_ptr[u]);
            if (g >= 0) begin_item(u, g);
            else m_act[u] = 1'b0;
        end
        m_pend[u] = m_pend[u] | cp;
        m_val[u]  = (m_val[u] & ~cp) | (xx & cp);
        m_ack[u]  = cp;
    endtask

    task automatic check_all(input int u);
        int e_sel;
        int e_d;
        int e_busy;
        e_sel  = m_act[u] ? m_cur[u] : 0;
        e_d    = m_act[u] ? int'(m_d[u]) : 0;
        e_busy = (m_pend[u] != 0 || m_act[u]) ? 1 : 0;
        chk($sformatf("u%0d_ack", u), 32'(ack_v[u]), 32'(m_ack[u]));
        chk($sformatf("u%0d_enable", u), 32'(en_v[u]), 32'(m_act[u]));
        chk($sformatf("u%0d_sel", u), 32'(sel_v[u]), e_sel);
        chk($sformatf("u%0d_d", u), 32'(d_v[u]), e_d);
        chk($sformatf("u%0d_busy", u), 32'(busy_v[u]), e_busy);
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_u%0d_ack", tag, u), 32'(ack_v[u]), 0);
            chk($sformatf("%s_u%0d_en", tag, u), 32'(en_v[u]), 0);
            chk($sformatf("%s_u%0d_sel", tag, u), 32'(sel_v[u]), 0);
            chk($sformatf("%s_u%0d_d", tag, u), 32'(d_v[u]), 0);
            chk($sformatf("%s_u%0d_busy", tag, u), 32'(busy_v[u]), 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) model_reset(u);
            else model_step(u, req_v[u], x_v[u]);
        end
        #1;
        for (int u = 0; u < 2; u++) check_all(u);
    endtask

    // asynchronous reset asserted mid-cycle, checked before the next edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        for (int u = 0; u < 2; u++) begin
            model_reset(u);
            req_v[u] = '0;
            x_v[u]   = '0;
            rel[u]   = '0;
        end
        cycle();
        #2 rst_n = 1'b1;
    endtask

    // random source: holds req until ack, keeps it through the ack cycle, then decides anew
    task automatic drive_src(input int u);
        for (int i = 0; i < 8; i++) begin
            if (m_ack[u][i]) begin
                rel[u][i] = 1'b1;
            end else if (!(req_v[u][i] && !rel[u][i])) begin
                rel[u][i] = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    req_v[u][i] = 1'b1;
                    x_v[u][i]   = 1'($urandom_range(0, 1));
                end else begin
                    req_v[u][i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            x_v[u]   = '0;
            req_v[u] = '0;
            rel[u]   = '0;
            model_reset(u);
        end
        cycle();
        cycle();
        check_zero("por");
        #2 rst_n = 1'b1;

        // single item on lane 5
        req_v[0] = 8'h20;
        x_v[0]   = 8'h20;
        cycle();
        chk("t1_ack", 32'(ack_v[0]), 'h20);
        chk("t1_en_early", 32'(en_v[0]), 0);
        req_v[0] = '0;
        x_v[0]   = '0;
        cycle();
        chk("t1_en", 32'(en_v[0]), 1);
        chk("t1_sel", 32'(sel_v[0]), 5);
        chk("t1_d", 32'(d_v[0]), 1);
        chk("t1_ack_once", 32'(ack_v[0]), 0);
        cycle();
        chk("t1_en_off", 32'(en_v[0]), 0);
        chk("t1_sel_off", 32'(sel_v[0]), 0);
        chk("t1_d_off", 32'(d_v[0]), 0);
        chk("t1_busy_off", 32'(busy_v[0]), 0);

        // all lanes at once from ptr=0
        do_reset();
        pat      = 8'hA5;
        req_v[0] = '1;
        x_v[0]   = pat;
        cycle();
        chk("t2_ack", 32'(ack_v[0]), 'hFF);
        req_v[0] = '0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            chk("t2_en", 32'(en_v[0]), 1);
            chk("t2_sel", 32'(sel_v[0]), k);
            chk("t2_d", 32'(pat[k]), 32'(d_v[0]) ^ 0);
            cycle();
        end
        chk("t2_done", 32'(en_v[0]), 0);

        // lane 7 alone, then lanes 0 and 7 together: pointer wrapped to 0
        req_v[0] = 8'h80;
        x_v[0]   = 8'h80;
        cycle();
        req_v[0] = '0;
        cycle();
        chk("t3_sel7", 32'(sel_v[0]), 7);
        cycle();
        req_v[0] = 8'h81;
        x_v[0]   = 8'h81;
        cycle();
        chk("t3_ack", 32'(ack_v[0]), 'h81);
        req_v[0] = '0;
        cycle();
        chk("t3_first", 32'(sel_v[0]), 0);
        chk("t3_first_en", 32'(en_v[0]), 1);
        cycle();
        chk("t3_second", 32'(sel_v[0]), 7);
        chk("t3_second_d", 32'(d_v[0]), 1);
        cycle();
        chk("t3_idle", 32'(en_v[0]), 0);

        // HOLD_CYCLES=3: second lane-2 item requested while the first is in flight
        req_v[1] = 8'h04;
        x_v[1]   = 8'h04;
        cycle();
        chk("t4_ack1", 32'(ack_v[1]), 'h04);
        for (int c = 2; c <= 10; c++) begin
            cycle();
            chk($sformatf("t4_en_c%0d", c), 32'(en_v[1]), 32'(t4_en[c-2]));
            chk($sformatf("t4_d_c%0d", c), 32'(d_v[1]), 32'(t4_d[c-2]));
            chk($sformatf("t4_sel_c%0d", c), 32'(sel_v[1]), t4_en[c-2] ? 2 : 0);
            chk($sformatf("t4_ack_c%0d", c), 32'(ack_v[1]), t4_ack[c-2]);
            if (c == 2) x_v[1] = '0;
            if (c == 6) req_v[1] = '0;
        end

        // reset during SEND with 4 lanes pending
        req_v[0] = 8'h0F;
        x_v[0]   = 8'($urandom);
        cycle();
        req_v[0] = '0;
        cycle();
        chk("t5_sending", 32'(en_v[0]), 1);
        chk("t5_busy", 32'(busy_v[0]), 1);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("t5_no_en", 32'(en_v[0]), 0);
            chk("t5_no_busy", 32'(busy_v[0]), 0);
        end

        // req[3] held through its ack cycle: exactly one item
        na = 0;
        ne = 0;
        req_v[0] = 8'h08;
        x_v[0]   = 8'h08;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            if (ack_v[0] == 8'h08) na++;
            if (en_v[0] === 1'b1 && sel_v[0] == 3'd3) ne++;
            if (c == 2) req_v[0] = '0;
        end
        chk("t6_acks", na, 1);
        chk("t6_items", ne, 1);

        // randomized traffic on both instances with a reset in the middle
        for (int n = 0; n < 700; n++) begin
            drive_src(0);
            drive_src(1);
            cycle();
            if (n == 350) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8to1_rr_serializer.md
Name: mux_8to1_rr_serializer

Overview:
- Transmit-side counterpart of the 1-to-8 demultiplexer: gathers 1-bit items from 8 source lanes and serialises them onto a single (d, sel, enable) triple.
- The triple connects directly to the demux on the far side, so each item arrives on output lane sel.
- Per-lane capture registers with req/ack handshake; round-robin arbitration; programmable hold time per item.

Parameters:
HOLD_CYCLES, 1, cycles each item is presented with enable=1; legal range 1..255; hold counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
x  input  8  data bit per source lane; must be stable while req[i]=1
req  input  8  per-lane request; level, held by the source until ack[i]
ack  output  8  per-lane one-cycle accept pulse (registered)
d  output  1  serialised data bit toward the demux
sel  output  3  destination lane index toward the demux
enable  output  1  qualifies d/sel; high only while an item is presented
busy  output  1  OR of all pending bits OR enable (combinational from registers)

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, data_q=0, ack=0, d=0, sel=0, enable=0, ptr=0, hold counter=0, state=IDLE. Reset asserted mid-transfer drops all pending items immediately. No ack or enable is produced for dropped items.
- Capture, per lane i, each rising edge:
  - If req[i]=1 and pending[i]=0: data_q[i]<=x[i], pending[i]<=1, and ack[i]=1 for exactly the next cycle.
  - If req[i]=1 and pending[i]=1: no capture and no ack. The source keeps req asserted; this is a stall, never a drop.
- Source rule: deassert req[i] (or present a new item) in the cycle after ack[i]=1. req[i] high during the ack cycle is ignored because pending[i]=1.
- FSM states: IDLE and SEND.
- IDLE:
  - If any pending bit is set, grant g = first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - Registered outputs next cycle: enable=1, sel=g, d=data_q[g], hold counter=HOLD_CYCLES-1, state=SEND.
  - If no pending bit is set, stay in IDLE.
- SEND:
  - d, sel and enable are held constant; the hold counter decrements each cycle.
  - On the edge ending the last hold cycle (counter=0): pending[g]<=0 and ptr<=g+1 mod 8 (7 wraps to 0).
  - At that same edge, the next grant is computed from the pending register with bit g masked, using the new ptr order.
  - If a next grant exists: enter SEND again with no bubble, so enable stays 1 and sel/d update.
  - If none exists: enable<=0, d<=0, sel<=0, state=IDLE.
- Lane g cannot recapture while its item is in flight. A new req[g] is accepted on the edge after pending[g] clears.
- Simultaneous events:
  - Captures and grants happen in the same cycle; a lane captured at edge E is eligible for grant from edge E+1.
  - Captures on several lanes in one cycle are all accepted, each with its own ack pulse.
- Invariants:
  - Per lane, items are delivered in capture order, with at most one outstanding item per lane.
  - Round-robin guarantees each pending lane is served within 7 other items.
- Latency, empty system, HOLD_CYCLES=1: req[i] seen at edge E0; ack[i] high in cycle 1; enable=1 with sel=i in cycle 2; enable=0 in cycle 3.
- Invariant: enable=0 implies d=0 and sel=0.

Test Plan:
- Reset, then pulse req[5]=1 with x[5]=1 until ack -> ack=8'h20 for exactly one cycle; two cycles later d=1, sel=5, enable=1 for one cycle; then all outputs 0 and busy=0.
- Assert req=8'hFF with x=8'hA5 simultaneously, ptr=0 -> ack=8'hFF in one cycle; sel sequence 0..7 back-to-back with no enable gap; d sequence 1,0,1,0,0,1,0,1.
- Serve lane 7 alone, then request lanes 0 and 7 together -> lane 0 served first (ptr wrapped to 0), then lane 7.
- HOLD_CYCLES=3, request lane 2 during lane 2's own SEND -> no ack until pending[2] clears; lane 2's first item is held for 3 cycles; the second item follows with the correct d.
- Deassert rst_n mid-SEND with 4 lanes pending -> outputs 0 asynchronously; after release, no enable until a new req.
- Hold req[3] high during the ack cycle -> no second capture; exactly one item delivered on sel=3.
